alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Registered, parametrised ALU control unit: decodes {alu_op, funct} into a CTRL_W-bit ALU control code with a valid/ready handshake.
- Expands SHA macro-functs (sigma, sum, ch, maj) into 3-4 micro-op sequences, one micro-op per accepted output beat.
- Sits between the main control / ID stage and the ALU, replacing the purely combinational 2-bit decoder.

Parameters:
- FUNCT_W, 6, funct field width; only the low 6 bits are decoded, and upper bits must be 0 for a legal code.
- CTRL_W, 4, ALU control output width (minimum 4); codes are zero-extended.
- SEQ_MAX, 4, maximum micro-ops per macro (minimum 4); sets uop_idx width IDX_W = $clog2(SEQ_MAX).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decode request present
- in_ready  out  1  request accepted when in_valid && in_ready
- alu_op  in  2  ALUOp from main control
- funct  in  FUNCT_W  instruction function field
- out_valid  out  1  alu_ctrl/uop_idx/uop_last valid
- out_ready  in  1  ALU consumes beat when out_valid && out_ready
- alu_ctrl  out  CTRL_W  ALU control code
- uop_idx  out  IDX_W  micro-op index within the current instruction (0 for single ops)
- uop_last  out  1  final micro-op of the instruction
- illegal  out  1  unknown funct with alu_op=2'b10 (sticky for that beat only)

Behaviour:
- Codes (package): ADD=0, SUB=1, DES=2, SW=3, AND=4, OR=5, XOR=6, NOT=7, ROTR=8, SHR=9, ANDN=10.
- Single-op decode:
  - alu_op 00 -> ADD.
  - alu_op 01 -> DES.
  - alu_op 11 -> SUB.
  - alu_op 10 with funct 100000 -> ADD; 100010 -> DES; 101010 -> SW; 100100 -> AND; 100101 -> OR; 100110 -> XOR; 100111 -> NOT.
- Macro decode (alu_op 10):
  - 110000 SIG0 {ROTR,ROTR,SHR}
  - 110001 SIG1 {ROTR,ROTR,SHR}
  - 110010 SUM0 {ROTR,ROTR,ROTR}
  - 110011 SUM1 {ROTR,ROTR,ROTR}
  - 110100 CH {AND,ANDN,XOR}
  - 110101 MAJ {AND,AND,XOR,XOR}
- Any other funct with alu_op 10 -> single beat, alu_ctrl=ADD, illegal=1.
- Reset (async, immediate): out_valid=0, alu_ctrl=0, uop_idx=0, uop_last=0, illegal=0, state=IDLE. in_ready=1 once reset deasserts.
- FSM states IDLE, HOLD, SEQ.
- IDLE:
  - out_valid=0; in_ready=1.
  - On accept: register uop 0 next edge (latency 1 cycle); out_valid=1.
  - Next state is HOLD if the op has length 1, else SEQ.
- HOLD (single op or last macro beat presented):
  - in_ready = out_ready; back-to-back accepts give one beat per cycle.
  - On out_ready && !in_valid -> IDLE, out_valid=0.
  - On out_ready && in_valid -> load the new op (same rules as IDLE).
  - !out_ready -> all outputs held stable.
- SEQ:
  - in_ready=0.
  - On out_ready: uop_idx+1 with alu_ctrl from the macro table.
  - uop_last=1 exactly when uop_idx = len-1; that beat moves the FSM to HOLD.
  - !out_ready -> hold all outputs.
- Outputs never change while out_valid && !out_ready.
- Inputs are sampled only on accept; changes to alu_op/funct in SEQ are ignored.
- Reset mid-sequence aborts the macro; no further beats are issued.
- Simultaneous last-beat consume and new request (HOLD, out_ready && in_valid) -> no bubble.

Decomposition:
- Package alu_ctrl_pkg:
  - alu_ctrl_e enum (codes above).
  - ALUOP_* and FUNCT_* localparams.
  - Macro length constants.
  - Function macro_uop(funct, idx) returning alu_ctrl_e.
- One sub-module alu_ctrl_decode: combinational {alu_op, funct, idx} -> {code, len, illegal}.
- alu_ctrl_seq holds the FSM, index counter and output registers.

Test Plan:
- Reset then alu_op=10, funct=100000, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0, uop_last=1, illegal=0; the following cycle, with no request, out_valid=0.
- Back-to-back: cycle0 funct 100010, cycle1 funct 101010, cycle2 alu_op 11, all out_ready=1 -> alu_ctrl stream 2,3,1 on consecutive cycles, in_ready constant 1.
- MAJ (110101) with out_ready=1 -> alu_ctrl 4,4,6,6 with uop_idx 0..3; uop_last only on idx 3; in_ready=0 for idx 0-2.
- SIG0 with out_ready low for 2 cycles at idx 1 -> alu_ctrl=8, uop_idx=1 held for 2 cycles, then 9 at idx 2.
- alu_op 10, funct 111111 -> alu_ctrl=0, illegal=1 for one beat, uop_last=1.
- CH accepted, reset asserted after the idx 1 beat -> outputs zero immediately; after release, out_valid=0 and in_ready=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, decode constants and SHA macro micro-op tables.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_DES  = 4'd2,
        ALU_SW   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOT  = 4'd7,
        ALU_ROTR = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_ANDN = 4'd10
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SEQ
    } seq_state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_DES   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_DES  = 6'b100010;
    localparam logic [5:0] FUNCT_SW   = 6'b101010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOT  = 6'b100111;
    localparam logic [5:0] FUNCT_SIG0 = 6'b110000;
    localparam logic [5:0] FUNCT_SIG1 = 6'b110001;
    localparam logic [5:0] FUNCT_SUM0 = 6'b110010;
    localparam logic [5:0] FUNCT_SUM1 = 6'b110011;
    localparam logic [5:0] FUNCT_CH   = 6'b110100;
    localparam logic [5:0] FUNCT_MAJ  = 6'b110101;

    localparam int unsigned LEN_SINGLE = 1;
    localparam int unsigned LEN_SIG    = 3;
    localparam int unsigned LEN_SUM    = 3;
    localparam int unsigned LEN_CH     = 3;
    localparam int unsigned LEN_MAJ    = 4;

    function automatic int unsigned macro_len(input logic [5:0] f);
        case (f)
            FUNCT_SIG0, FUNCT_SIG1: macro_len = LEN_SIG;
            FUNCT_SUM0, FUNCT_SUM1: macro_len = LEN_SUM;
            FUNCT_CH:               macro_len = LEN_CH;
            FUNCT_MAJ:              macro_len = LEN_MAJ;
            default:                macro_len = LEN_SINGLE;
        endcase
    endfunction

    function automatic alu_ctrl_e macro_uop(input logic [5:0] f, input int unsigned idx);
        case (f)
            FUNCT_SIG0, FUNCT_SIG1: macro_uop = (idx < 2) ? ALU_ROTR : ALU_SHR;
            FUNCT_SUM0, FUNCT_SUM1: macro_uop = ALU_ROTR;
            FUNCT_CH: begin
                case (idx)
                    0:       macro_uop = ALU_AND;
                    1:       macro_uop = ALU_ANDN;
                    default: macro_uop = ALU_XOR;
                endcase
            end
            FUNCT_MAJ:              macro_uop = (idx < 2) ? ALU_AND : ALU_XOR;
            default:                macro_uop = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational decode of {alu_op, funct, micro-op index} into code, macro length and illegal flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int IDX_W   = 2,
    parameter int LEN_W   = 3
) (
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [IDX_W-1:0]   idx,
    output alu_ctrl_e          code,
    output logic [LEN_W-1:0]   len,
    output logic               illegal
);

    logic [5:0] f6;
    logic       hi_zero;

    assign f6      = funct[5:0];
    // Bits above the 6-bit field must be zero for the funct to be legal.
    assign hi_zero = (funct & ~FUNCT_W'(6'h3F)) == '0;

    always_comb begin
        code    = ALU_ADD;
        len     = LEN_W'(LEN_SINGLE);
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_DES: code = ALU_DES;
            ALUOP_SUB: code = ALU_SUB;
            default: begin
                if (!hi_zero) begin
                    illegal = 1'b1;
                end else begin
                    case (f6)
                        FUNCT_ADD: code = ALU_ADD;
                        FUNCT_DES: code = ALU_DES;
                        FUNCT_SW:  code = ALU_SW;
                        FUNCT_AND: code = ALU_AND;
                        FUNCT_OR:  code = ALU_OR;
                        FUNCT_XOR: code = ALU_XOR;
                        FUNCT_NOT: code = ALU_NOT;
                        FUNCT_SIG0, FUNCT_SIG1, FUNCT_SUM0,
                        FUNCT_SUM1, FUNCT_CH, FUNCT_MAJ: begin
                            code = macro_uop(f6, 32'(idx));
                            len  = LEN_W'(macro_len(f6));
                        end
                        default:   illegal = 1'b1;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit: single-op decode plus SHA macro expansion behind a valid/ready handshake.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 4,
    parameter int SEQ_MAX = 4,
    localparam int IDX_W  = $clog2(SEQ_MAX)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic [IDX_W-1:0]   uop_idx,
    output logic               uop_last,
    output logic               illegal
);

    localparam int LEN_W = $clog2(SEQ_MAX + 1);

    seq_state_e         state, state_nxt;
    logic [1:0]         op_q;
    logic [FUNCT_W-1:0] funct_q;
    logic [LEN_W-1:0]   len_q;

    logic               accept, advance, retire;
    logic [1:0]         dec_op;
    logic [FUNCT_W-1:0] dec_funct;
    logic [IDX_W-1:0]   dec_idx;
    alu_ctrl_e          dec_code;
    logic [LEN_W-1:0]   dec_len;
    logic               dec_illegal;
    logic               dec_single;
    logic               step_last;

    // One decoder serves both a fresh request (index 0) and the next beat of a running macro.
    assign accept    = in_valid && in_ready;
    assign advance   = (state == ST_SEQ) && out_ready;
    assign retire    = (state == ST_HOLD) && out_ready && !in_valid;
    assign dec_op    = accept ? alu_op : op_q;
    assign dec_funct = accept ? funct : funct_q;
    assign dec_idx   = accept ? '0 : uop_idx + IDX_W'(1);
    assign dec_single = (dec_len == LEN_W'(1));
    assign step_last  = (LEN_W'(dec_idx) == len_q - LEN_W'(1));
    assign out_valid  = (state != ST_IDLE);

    alu_ctrl_decode #(
        .FUNCT_W (FUNCT_W),
        .IDX_W   (IDX_W),
        .LEN_W   (LEN_W)
    ) u_decode (
        .alu_op  (dec_op),
        .funct   (dec_funct),
        .idx     (dec_idx),
        .code    (dec_code),
        .len     (dec_len),
        .illegal (dec_illegal)
    );

    always_comb begin
        in_ready  = 1'b0;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = dec_single ? ST_HOLD : ST_SEQ;
            end
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) state_nxt = dec_single ? ST_HOLD : ST_SEQ;
                    else          state_nxt = ST_IDLE;
                end
            end
            ST_SEQ: begin
                if (out_ready && step_last) state_nxt = ST_HOLD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            alu_ctrl <= '0;
            uop_idx  <= '0;
            uop_last <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_ctrl <= CTRL_W'(dec_code);
                uop_idx  <= '0;
                uop_last <= dec_single;
                illegal  <= dec_illegal;
            end else if (advance) begin
                alu_ctrl <= CTRL_W'(dec_code);
                uop_idx  <= dec_idx;
                uop_last <= step_last;
                illegal  <= 1'b0;
            end else if (retire) begin
                alu_ctrl <= '0;
                uop_idx  <= '0;
                uop_last <= 1'b0;
                illegal  <= 1'b0;
            end
        end
    end

    // Captured request: only read while a macro is running, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= alu_op;
            funct_q <= funct;
            len_q   <= dec_len;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: vector table plus scoreboard of expected output beats.
module tb_alu_ctrl_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_ctrl;
    logic [1:0] uop_idx;
    logic       uop_last;
    logic       illegal;

    alu_ctrl_seq #(.FUNCT_W(6), .CTRL_W(4), .SEQ_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .uop_idx   (uop_idx),
        .uop_last  (uop_last),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // codes: nibble b holds the expected alu_ctrl for micro-op b
    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        int          len;
        logic [15:0] codes;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [3:0] code;
        logic [1:0] idx;
        logic       last;
        logic       ill;
    } beat_t;

    localparam int NVEC = 20;
    vec_t  vecs [NVEC];
    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int i, output int waited);
        beat_t b;
        in_valid = 1'b1;
        alu_op   = vecs[i].op;
        funct    = vecs[i].funct;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout vector=%0d actual=no_accept required=accept", i);
        end else begin
            for (int k = 0; k < vecs[i].len; k++) begin
                b.code = vecs[i].codes[4*k +: 4];
                b.idx  = 2'(k);
                b.last = (k == vecs[i].len - 1);
                b.ill  = vecs[i].ill;
                sb.push_back(b);
            end
        end
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'h00;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_beats", sb.size(), 0);
        step();
    endtask

    // Scoreboard monitor: pop on each consumed beat, and check stalled beats stay frozen.
    beat_t held;
    logic  stall_prev = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_code", alu_ctrl, held.code);
                chk("hold_idx", uop_idx, held.idx);
                chk("hold_last", uop_last, held.last);
                chk("hold_illegal", illegal, held.ill);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=code%0d required=no_beat", alu_ctrl);
                end else begin
                    e = sb.pop_front();
                    chk("beat_code", alu_ctrl, e.code);
                    chk("beat_idx", uop_idx, e.idx);
                    chk("beat_last", uop_last, e.last);
                    chk("beat_illegal", illegal, e.ill);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = '{code: alu_ctrl, idx: uop_idx, last: uop_last, ill: illegal};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        vecs[0]  = '{2'b00, 6'h00, 1, 16'h0000, 1'b0};
        vecs[1]  = '{2'b01, 6'h00, 1, 16'h0002, 1'b0};
        vecs[2]  = '{2'b11, 6'h00, 1, 16'h0001, 1'b0};
        vecs[3]  = '{2'b10, 6'h20, 1, 16'h0000, 1'b0};
        vecs[4]  = '{2'b10, 6'h22, 1, 16'h0002, 1'b0};
        vecs[5]  = '{2'b10, 6'h2A, 1, 16'h0003, 1'b0};
        vecs[6]  = '{2'b10, 6'h24, 1, 16'h0004, 1'b0};
        vecs[7]  = '{2'b10, 6'h25, 1, 16'h0005, 1'b0};
        vecs[8]  = '{2'b10, 6'h26, 1, 16'h0006, 1'b0};
        vecs[9]  = '{2'b10, 6'h27, 1, 16'h0007, 1'b0};
        vecs[10] = '{2'b10, 6'h30, 3, 16'h0988, 1'b0};
        vecs[11] = '{2'b10, 6'h31, 3, 16'h0988, 1'b0};
        vecs[12] = '{2'b10, 6'h32, 3, 16'h0888, 1'b0};
        vecs[13] = '{2'b10, 6'h33, 3, 16'h0888, 1'b0};
        vecs[14] = '{2'b10, 6'h34, 3, 16'h06A4, 1'b0};
        vecs[15] = '{2'b10, 6'h35, 4, 16'h6644, 1'b0};
        vecs[16] = '{2'b10, 6'h3F, 1, 16'h0000, 1'b1};
        vecs[17] = '{2'b10, 6'h21, 1, 16'h0000, 1'b1};
        vecs[18] = '{2'b10, 6'h36, 1, 16'h0000, 1'b1};
        vecs[19] = '{2'b11, 6'h3F, 1, 16'h0001, 1'b0};

        reset = 1'b1;
        idle();
        out_ready = 1'b1;
        step();
        step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_alu_ctrl", alu_ctrl, 0);
        chk("reset_uop_idx", uop_idx, 0);
        chk("reset_uop_last", uop_last, 0);
        chk("reset_illegal", illegal, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        step();

        // Single R-type ADD: one-cycle latency, then idle again.
        send(3, w);
        idle();
        @(negedge clk);
        chk("add_out_valid", out_valid, 1);
        chk("add_alu_ctrl", alu_ctrl, 0);
        chk("add_uop_last", uop_last, 1);
        chk("add_illegal", illegal, 0);
        step();
        @(negedge clk);
        chk("add_then_idle", out_valid, 0);
        step();

        // Back-to-back singles: DES, SW, SUB with no accept stall.
        wsum = 0;
        send(4, w); wsum += w;
        send(5, w); wsum += w;
        send(2, w); wsum += w;
        idle();
        chk("b2b_accept_stalls", wsum, 0);
        drain();

        // Whole table streamed back-to-back.
        for (int i = 0; i < NVEC; i++) send(i, w);
        idle();
        drain();

        // MAJ: in_ready low while the first three micro-ops are presented.
        send(15, w);
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("maj_idx", uop_idx, k);
            chk("maj_in_ready", in_ready, (k == 3) ? 1 : 0);
            chk("maj_last", uop_last, (k == 3) ? 1 : 0);
            step();
        end
        drain();

        // SIG0 stalled for two cycles at index 1.
        send(10, w);
        idle();
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("sig0_stall_code", alu_ctrl, 8);
        chk("sig0_stall_idx", uop_idx, 1);
        step();
        @(negedge clk);
        chk("sig0_stall2_code", alu_ctrl, 8);
        chk("sig0_stall2_idx", uop_idx, 1);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("sig0_resume_code", alu_ctrl, 9);
        chk("sig0_resume_idx", uop_idx, 2);
        drain();

        // Illegal funct: one beat, flag clears afterwards.
        send(16, w);
        idle();
        @(negedge clk);
        chk("illegal_flag", illegal, 1);
        chk("illegal_code", alu_ctrl, 0);
        chk("illegal_last", uop_last, 1);
        step();
        @(negedge clk);
        chk("illegal_cleared", illegal, 0);
        chk("illegal_then_idle", out_valid, 0);
        step();

        // CH aborted by reset after the index-1 beat is consumed.
        send(14, w);
        idle();
        step();
        step();
        reset = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_alu_ctrl", alu_ctrl, 0);
        chk("abort_uop_idx", uop_idx, 0);
        chk("abort_uop_last", uop_last, 0);
        chk("abort_illegal", illegal, 0);
        sb.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_release_valid", out_valid, 0);
        chk("abort_release_in_ready", in_ready, 1);
        step();
        @(negedge clk);
        chk("abort_no_more_beats", out_valid, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
